// File: rtl/pcc_pwm_drv_pkg.sv
// Shared definitions for the PWM drive stage: FSM encodings, default
// parameter values, and the saturation / slew helpers.
package pcc_pwm_drv_pkg;

    localparam int unsigned CMD_L_DEF     = 4;
    localparam int unsigned PWM_W_DEF     = 8;
    localparam int unsigned DEF_DIR_DEF   = 8;
    localparam int unsigned PRESCALE_DEF  = 4;
    localparam int unsigned SLEW_STEP_DEF = 16;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } pwm_state_e;

    // Clamp a signed value into the unsigned range 0..2^width-1.
    function automatic int sat_u(input int x, input int unsigned width);
        int hi;
        hi = (1 << width) - 1;
        if (x < 0) return 0;
        if (x > hi) return hi;
        return x;
    endfunction

    // Move cur toward tgt by at most step, landing exactly on tgt when close.
    function automatic int slew_to(input int cur, input int tgt, input int step);
        if (tgt > cur + step) return cur + step;
        if (tgt < cur - step) return cur - step;
        return tgt;
    endfunction

endpackage

// File: rtl/pcc_pwm_drv_if.sv
// Command-in / PWM-out bundle between the controller and the PWM drive stage.
interface pcc_pwm_drv_if #(
    parameter int unsigned CMD_L = 4,
    parameter int unsigned PWM_W = 8
);
    logic             en;
    logic [CMD_L-1:0] speed_cmd;
    logic [CMD_L-1:0] dir_cmd;
    logic             pwm_l;
    logic             pwm_r;
    logic [PWM_W-1:0] duty_l;
    logic [PWM_W-1:0] duty_r;
    logic             upd;

    modport master (
        output en, speed_cmd, dir_cmd,
        input  pwm_l, pwm_r, duty_l, duty_r, upd
    );

    modport slave (
        input  en, speed_cmd, dir_cmd,
        output pwm_l, pwm_r, duty_l, duty_r, upd
    );
endinterface

// File: rtl/pcc_pwm_drv_mix.sv
// Differential mixer: speed plus/minus steering, saturated to duty range.
// Purely combinational so the telemetry path can reuse it.
module pcc_pwm_drv_mix
    import pcc_pwm_drv_pkg::*;
#(
    parameter int unsigned CMD_L       = CMD_L_DEF,
    parameter int unsigned PWM_W       = PWM_W_DEF,
    parameter int unsigned DEF_DIR_CMD = DEF_DIR_DEF
) (
    input  logic [CMD_L-1:0] speed_cmd,
    input  logic [CMD_L-1:0] dir_cmd,
    output logic [PWM_W-1:0] mix_l,
    output logic [PWM_W-1:0] mix_r
);
    // Two guard bits: one for sign, one for base+steer overflow.
    localparam int unsigned MW = PWM_W + 2;

    logic signed [MW-1:0] base;
    logic signed [MW-1:0] delta;
    logic signed [MW-1:0] steer;
    logic signed [MW-1:0] sum_l;
    logic signed [MW-1:0] sum_r;

    always_comb begin
        base  = $signed(MW'(speed_cmd)) <<< (PWM_W - CMD_L);
        delta = $signed(MW'(dir_cmd)) - $signed(MW'(DEF_DIR_CMD));
        steer = delta <<< (PWM_W - CMD_L - 1);
        sum_l = base + steer;
        sum_r = base - steer;
        mix_l = PWM_W'(sat_u(int'(sum_l), PWM_W));
        mix_r = PWM_W'(sat_u(int'(sum_r), PWM_W));
    end

endmodule

// File: rtl/pcc_pwm_drv.sv
// Edge-aligned dual PWM driver with period-boundary double-buffered duties.
// Optional soft-start duty slewing when PCC_PWM_SLEW_EN is defined.
module pcc_pwm_drv
    import pcc_pwm_drv_pkg::*;
#(
    parameter int unsigned CMD_L       = CMD_L_DEF,
    parameter int unsigned PWM_W       = PWM_W_DEF,
    parameter int unsigned DEF_DIR_CMD = DEF_DIR_DEF,
    parameter int unsigned PRESCALE    = PRESCALE_DEF,
    parameter int unsigned SLEW_STEP   = SLEW_STEP_DEF
) (
    input  logic         clk,
    input  logic         rst,
    pcc_pwm_drv_if.slave bus
);
    localparam int unsigned PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PWM_W-1:0] CNT_MAX = '1;

    if (PWM_W <= CMD_L || PRESCALE < 1 || SLEW_STEP < 1) begin : g_bad_cfg
        $error("pcc_pwm_drv: invalid parameter set");
    end

    pwm_state_e       state;
    logic [PSW-1:0]   psc;
    logic [PWM_W-1:0] cnt;
    logic [PWM_W-1:0] duty_l_q;
    logic [PWM_W-1:0] duty_r_q;
    logic             pwm_l_q;
    logic             pwm_r_q;
    logic             upd_q;
    logic [PWM_W-1:0] mix_l;
    logic [PWM_W-1:0] mix_r;
    logic [PWM_W-1:0] nxt_l;
    logic [PWM_W-1:0] nxt_r;
    logic             tick;

    pcc_pwm_drv_mix #(
        .CMD_L       (CMD_L),
        .PWM_W       (PWM_W),
        .DEF_DIR_CMD (DEF_DIR_CMD)
    ) u_mix (
        .speed_cmd (bus.speed_cmd),
        .dir_cmd   (bus.dir_cmd),
        .mix_l     (mix_l),
        .mix_r     (mix_r)
    );

    // Value the shadow duties take at the next latch point.
    always_comb begin
        nxt_l = mix_l;
        nxt_r = mix_r;
`ifdef PCC_PWM_SLEW_EN
        nxt_l = PWM_W'(slew_to(int'(duty_l_q), int'(mix_l), int'(SLEW_STEP)));
        nxt_r = PWM_W'(slew_to(int'(duty_r_q), int'(mix_r), int'(SLEW_STEP)));
`endif
    end

    assign tick = (psc == PSW'(PRESCALE - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_OFF;
            psc      <= '0;
            cnt      <= '0;
            duty_l_q <= '0;
            duty_r_q <= '0;
            pwm_l_q  <= 1'b0;
            pwm_r_q  <= 1'b0;
            upd_q    <= 1'b0;
        end else begin
            upd_q <= 1'b0;
            unique case (state)
                ST_OFF: begin
                    psc      <= '0;
                    cnt      <= '0;
                    duty_l_q <= '0;
                    duty_r_q <= '0;
                    pwm_l_q  <= 1'b0;
                    pwm_r_q  <= 1'b0;
                    if (bus.en) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    duty_l_q <= nxt_l;
                    duty_r_q <= nxt_r;
                    psc      <= '0;
                    cnt      <= '0;
                    upd_q    <= 1'b1;
                    state    <= ST_RUN;
                end
                ST_RUN: begin
                    if (!bus.en) begin
                        state    <= ST_OFF;
                        psc      <= '0;
                        cnt      <= '0;
                        duty_l_q <= '0;
                        duty_r_q <= '0;
                        pwm_l_q  <= 1'b0;
                        pwm_r_q  <= 1'b0;
                    end else begin
                        pwm_l_q <= (cnt < duty_l_q);
                        pwm_r_q <= (cnt < duty_r_q);
                        psc     <= tick ? '0 : psc + 1'b1;
                        if (tick) begin
                            cnt <= cnt + 1'b1;
                            // Period boundary: swap in new duties glitch-free.
                            if (cnt == CNT_MAX) begin
                                duty_l_q <= nxt_l;
                                duty_r_q <= nxt_r;
                                upd_q    <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= ST_OFF;
            endcase
        end
    end

    assign bus.pwm_l  = pwm_l_q;
    assign bus.pwm_r  = pwm_r_q;
    assign bus.duty_l = duty_l_q;
    assign bus.duty_r = duty_r_q;
    assign bus.upd    = upd_q;

endmodule

// File: tb/tb_pcc_pwm_drv.sv
// Directed self-checking bench for pcc_pwm_drv at default parameters.
module tb_pcc_pwm_drv;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   per_hl, per_hr, per_early, per_dl_end, per_last_upd;

    pcc_pwm_drv_if bus ();

    pcc_pwm_drv u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Bounded wait for the next upd pulse; a timeout is a failed comparison.
    task automatic wait_upd(input int budget, input string tag);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < budget) begin
            @(posedge clk);
            #1;
            n++;
            seen = bus.upd;
        end
        chk(tag, int'(seen), 1);
    endtask

    // Observe one full 1024-clock period starting at an upd cycle; optionally
    // change the commands mid-period at sample index chg_at.
    task automatic run_period(input int chg_at, input logic [3:0] spd, input logic [3:0] dr);
        per_hl = 0;
        per_hr = 0;
        per_early = 0;
        per_dl_end = -1;
        for (int k = 1; k <= 1024; k++) begin
            @(posedge clk);
            #1;
            per_hl += int'(bus.pwm_l);
            per_hr += int'(bus.pwm_r);
            if (k < 1024 && bus.upd) per_early++;
            if (k == 1023) per_dl_end = int'(bus.duty_l);
            if (k == chg_at) begin
                bus.speed_cmd = spd;
                bus.dir_cmd   = dr;
            end
        end
        per_last_upd = int'(bus.upd);
    endtask

    initial begin
        int cnt_upd;
        int cnt_pwm;
        n_cmp = 0;
        n_err = 0;

        // Reset held with enable and commands active.
        rst = 1'b0;
        bus.en = 1'b1;
        bus.speed_cmd = 4'd5;
        bus.dir_cmd = 4'd3;
        cyc(3);
        chk("rst_pwm_l", int'(bus.pwm_l), 0);
        chk("rst_pwm_r", int'(bus.pwm_r), 0);
        chk("rst_duty_l", int'(bus.duty_l), 0);
        chk("rst_duty_r", int'(bus.duty_r), 0);
        chk("rst_upd", int'(bus.upd), 0);

        bus.en = 1'b0;
        rst = 1'b1;
        cnt_upd = 0;
        cnt_pwm = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            cnt_upd += int'(bus.upd);
            cnt_pwm += int'(bus.pwm_l) + int'(bus.pwm_r) + int'(bus.duty_l != 0);
        end
        chk("off_upd_cnt", cnt_upd, 0);
        chk("off_out_cnt", cnt_pwm, 0);

`ifdef PCC_PWM_SLEW_EN
        bus.speed_cmd = 4'd15;
        bus.dir_cmd = 4'd8;
        bus.en = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            wait_upd(1100, "slew_upd");
            chk("slew_duty_l", int'(bus.duty_l), 16 * i);
            chk("slew_duty_r", int'(bus.duty_r), 16 * i);
        end
        wait_upd(1100, "slew_hold_upd");
        chk("slew_hold", int'(bus.duty_l), 240);
`else
        // Straight ahead at half speed.
        bus.speed_cmd = 4'd8;
        bus.dir_cmd = 4'd8;
        bus.en = 1'b1;
        wait_upd(10, "load_upd");
        chk("half_duty_l", int'(bus.duty_l), 128);
        chk("half_duty_r", int'(bus.duty_r), 128);
        run_period(-1, 4'd0, 4'd0);
        chk("half_hi_l", per_hl, 512);
        chk("half_hi_r", per_hr, 512);
        chk("half_early", per_early, 0);
        chk("half_per_upd", per_last_upd, 1);

        // Mid-period command change only takes effect at the boundary.
        run_period(300, 4'd4, 4'd8);
        chk("mid_duty_hold", per_dl_end, 128);
        chk("mid_hi_l", per_hl, 512);
        chk("mid_upd", per_last_upd, 1);
        chk("mid_duty_new", int'(bus.duty_l), 64);
        run_period(-1, 4'd0, 4'd0);
        chk("q_hi_l", per_hl, 256);

        // Full speed, full right: left saturates high.
        bus.speed_cmd = 4'd15;
        bus.dir_cmd = 4'd15;
        run_period(-1, 4'd0, 4'd0);
        chk("max_duty_l", int'(bus.duty_l), 255);
        chk("max_duty_r", int'(bus.duty_r), 184);
        run_period(-1, 4'd0, 4'd0);
        chk("max_hi_l", per_hl, 1020);
        chk("max_hi_r", per_hr, 736);

        // Stopped, full left: left saturates low.
        bus.speed_cmd = 4'd0;
        bus.dir_cmd = 4'd0;
        run_period(-1, 4'd0, 4'd0);
        chk("min_duty_l", int'(bus.duty_l), 0);
        chk("min_duty_r", int'(bus.duty_r), 64);
        run_period(-1, 4'd0, 4'd0);
        chk("min_hi_l", per_hl, 0);
        chk("min_hi_r", per_hr, 256);

        // Drop enable while the pulse is high.
        bus.speed_cmd = 4'd8;
        bus.dir_cmd = 4'd8;
        run_period(-1, 4'd0, 4'd0);
        cyc(100);
        chk("drop_pre_pwm", int'(bus.pwm_l), 1);
        bus.en = 1'b0;
        cyc(1);
        chk("drop_pwm_l", int'(bus.pwm_l), 0);
        chk("drop_pwm_r", int'(bus.pwm_r), 0);
        chk("drop_duty_l", int'(bus.duty_l), 0);
        chk("drop_duty_r", int'(bus.duty_r), 0);
        bus.speed_cmd = 4'd15;
        cnt_upd = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            cnt_upd += int'(bus.upd);
        end
        chk("drop_off_upd", cnt_upd, 0);
        bus.en = 1'b1;
        wait_upd(10, "reen_upd");
        chk("reen_duty_l", int'(bus.duty_l), 240);
        chk("reen_duty_r", int'(bus.duty_r), 240);
        run_period(-1, 4'd0, 4'd0);
        chk("reen_hi_l", per_hl, 960);
        chk("reen_early", per_early, 0);
        chk("reen_per_upd", per_last_upd, 1);
`endif

        // Asynchronous reset mid-period.
        cyc(50);
        chk("arst_pre_pwm", int'(bus.pwm_l), 1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_pwm_l", int'(bus.pwm_l), 0);
        chk("arst_duty_l", int'(bus.duty_l), 0);
        chk("arst_upd", int'(bus.upd), 0);
        bus.en = 1'b0;
        cyc(1);
        rst = 1'b1;
        cnt_pwm = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            cnt_pwm += int'(bus.pwm_l) + int'(bus.pwm_r) + int'(bus.upd);
        end
        chk("arst_quiet", cnt_pwm, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pcc_pwm_drv.md
Name: pcc_pwm_drv

Overview:
- Downstream stage of the proportional command controller.
- Consumes the smoothed speed and direction commands and mixes them into left/right differential wheel duty cycles.
- Generates two edge-aligned PWM outputs for the motor driver.
- Duty values are double-buffered and only change at PWM period boundaries, so every output pulse is glitch-free.

Parameters:
- cmd_l, 4: command width; must match the controller's command length.
- pwm_w, 8: PWM counter/duty width; must be greater than cmd_l.
- def_dir_cmd, 8: direction command meaning "straight ahead".
- prescale, 4: clocks per PWM tick; must be at least 1.
- slew_step, 16: maximum duty change per period (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- en  in  1  drive enable.
- speed_cmd  in  cmd_l  processed speed command.
- dir_cmd  in  cmd_l  processed direction command.
- pwm_l  out  1  left motor PWM.
- pwm_r  out  1  right motor PWM.
- duty_l  out  pwm_w  active left duty (shadow register).
- duty_r  out  pwm_w  active right duty (shadow register).
- upd  out  1  one-cycle pulse when new duties are latched.

Behaviour:
- Reset (rst=0, async): state=OFF; prescaler=0; period counter=0; pwm_l, pwm_r, duty_l, duty_r and upd all 0.
- Mixer (combinational):
  - base = speed_cmd << (pwm_w-cmd_l).
  - delta = signed(dir_cmd) - def_dir_cmd, range -8..+7 at defaults.
  - steer = delta << (pwm_w-cmd_l-1).
  - mix_l = base + steer; mix_r = base - steer.
  - Compute in pwm_w+2 signed bits, then saturate to 0..2^pwm_w-1.
- Tick: prescaler counts 0..prescale-1; tick asserts in the cycle where prescaler = prescale-1.
- Period counter: increments on tick and wraps from 2^pwm_w-1 to 0. Period = 2^pwm_w*prescale clocks (1024 at defaults).
- FSM OFF:
  - Counters held at 0; pwm outputs 0; duties 0.
  - en=1 -> LOAD.
- FSM LOAD (one cycle):
  - duty_l/duty_r <= mix (or slewed value); counters <= 0.
  - upd=1 in the following cycle.
  - -> RUN.
- FSM RUN:
  - pwm_x registered as (counter < duty_x), so pwm is one clock behind the counter. Duty 0 gives constant low; duty 2^pwm_w-1 gives high for all but one tick per period.
  - On tick with counter = 2^pwm_w-1: duties <= mix, upd=1 in the next cycle, counter wraps to 0.
  - en=0 -> OFF. On the next edge, pwm outputs, duties and counters are cleared.
- Command changes mid-period are ignored until the next boundary; only the values present in the latching cycle are used.
- en toggling 1->0->1: always passes through OFF then LOAD, so the new period starts from counter 0.
- Reset mid-period: immediate async clear; no partial pulse afterwards.
- upd never asserts in OFF.

Optional Feature:
- Macro: PCC_PWM_SLEW_EN.
- Defined:
  - At each latch (LOAD and boundary), each duty moves toward mix by at most slew_step per latch, saturating at mix.
  - LOAD starts from the current shadow value, which is 0 after OFF. This gives a soft start.
- Undefined: duty is loaded directly with mix, and the slew_step parameter is unused.

Decomposition:
- Shared header pcc_pwm_defs.vh:
  - FSM state encodings (OFF, LOAD, RUN).
  - Saturation function sat_u(x, width).
  - Slew function slew_to(cur, tgt, step).
- Sub-module pcc_pwm_mix: purely combinational mixer (speed_cmd, dir_cmd -> mix_l, mix_r), parameterised on cmd_l, pwm_w and def_dir_cmd, so it can be reused by the telemetry path.

Test Plan:
- rst=0 with en=1 and commands nonzero -> all outputs 0; after release with en=0, outputs stay 0 and upd never pulses.
- en=1, speed=8, dir=8 -> upd after LOAD, duty_l=duty_r=128; pwm high 512 clocks of each 1024-clock period; upd every 1024 clocks.
- speed=15, dir=15 -> duty_l=255 (saturated), duty_r=184. speed=0, dir=0 -> duty_l=0 (saturated), duty_r=64; pwm_l constantly low.
- Running at duty 128, change speed to 4 at clock 300 of the period -> duty and pwm unchanged until the boundary; then duty=64 and upd pulses.
- Drop en at clock 100 while pwm high -> pwm low and duties 0 on the next edge. Re-raise en -> LOAD, upd, fresh period from counter 0.
- With PCC_PWM_SLEW_EN, enable at speed=15, dir=8 -> duty sequence 16, 32, ..., 240, one step per upd. Without the macro -> 240 immediately.
